// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, immediate formats and the packed
// control-word layout carried from decode into the ID/EX register.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    // Control word, MSB first: reg_write, alu_src, mem_read, mem_write,
    // mem_to_reg, branch, jump, alu_op[1:0]
    localparam int CTRL_W          = 9;
    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_ALU_SRC    = 7;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_JUMP       = 2;
    localparam int CTRL_ALU_OP     = 0;

    // alu_op: plain add (address/upper-imm/link), branch compare, R funct, I funct
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    // 32-bit signed immediate; the caller sign-extends to its datapath width
    function automatic logic signed [31:0] gen_imm(input logic [31:0] ins,
                                                   input imm_fmt_t fmt);
        logic signed [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, x0 hard-wired to zero. Optional same-cycle writeback bypass on
// the read ports is enabled by defining DECODE_WB_BYPASS_EN.
module decode_regfile
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      wr_rd,
    input  logic [XLEN-1:0] wr_data
);
    localparam int         AW     = $clog2(NREG);
    localparam logic [5:0] NREG_L = 6'(NREG);

    logic [XLEN-1:0] regs [NREG];

    // Write port; x0 and indices beyond the implemented file are discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wr_rd != 5'd0 && {1'b0, wr_rd} < NREG_L) begin
            regs[wr_rd[AW-1:0]] <= wr_data;
        end
    end

    // Read port 1
    always_comb begin
        rs1_data = '0;
        if (rs1 != 5'd0 && {1'b0, rs1} < NREG_L) begin
            rs1_data = regs[rs1[AW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
            if (we && wr_rd == rs1) rs1_data = wr_data;
`endif
        end
    end

    // Read port 2
    always_comb begin
        rs2_data = '0;
        if (rs2 != 5'd0 && {1'b0, rs2} < NREG_L) begin
            rs2_data = regs[rs2[AW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
            if (we && wr_rd == rs2) rs2_data = wr_data;
`endif
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the IF/ID instruction, reads operands, detects
// load-use hazards and loads the ID/EX register. Writeback-to-read bypass in
// the register file is controlled by DECODE_WB_BYPASS_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_id_valid,
    input  logic [XLEN-1:0]   i_if_id_pc,
    input  logic [31:0]       i_if_id_instruction,
    input  logic              i_wb_we,
    input  logic [4:0]        i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic              i_ex_hold,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_ex_valid,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [XLEN-1:0]   o_ex_rs1_data,
    output logic [XLEN-1:0]   o_ex_rs2_data,
    output logic [XLEN-1:0]   o_ex_imm,
    output logic [4:0]        o_ex_rs1,
    output logic [4:0]        o_ex_rs2,
    output logic [4:0]        o_ex_rd,
    output logic [CTRL_W-1:0] o_ex_ctrl,
    output logic              o_ex_illegal
);
    localparam bit SMALL_RF = (NREG == 16);

    logic [4:0]        rs1_f, rs2_f, rd_f;
    logic [CTRL_W-1:0] ctrl_raw, ctrl_d;
    imm_fmt_t          fmt;
    logic              use_rs1, use_rs2, use_rd, known, bad_reg, illegal_d;
    logic [XLEN-1:0]   imm_d, rs1_data_d, rs2_data_d;

    assign rs1_f = i_if_id_instruction[19:15];
    assign rs2_f = i_if_id_instruction[24:20];
    assign rd_f  = i_if_id_instruction[11:7];

    // Opcode decode: control bits, immediate format and which register fields are live
    always_comb begin
        ctrl_raw = '0;
        fmt      = IMM_NONE;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        known    = 1'b1;
        case (i_if_id_instruction[6:0])
            OP_R: begin
                ctrl_raw[CTRL_REG_WRITE]    = 1'b1;
                ctrl_raw[CTRL_ALU_OP +: 2]  = ALU_OP_RTYPE;
                {use_rs1, use_rs2, use_rd}  = 3'b111;
            end
            OP_IALU: begin
                ctrl_raw[CTRL_REG_WRITE]    = 1'b1;
                ctrl_raw[CTRL_ALU_SRC]      = 1'b1;
                ctrl_raw[CTRL_ALU_OP +: 2]  = ALU_OP_ITYPE;
                fmt                         = IMM_I;
                {use_rs1, use_rd}           = 2'b11;
            end
            OP_LOAD: begin
                ctrl_raw[CTRL_REG_WRITE]    = 1'b1;
                ctrl_raw[CTRL_ALU_SRC]      = 1'b1;
                ctrl_raw[CTRL_MEM_READ]     = 1'b1;
                ctrl_raw[CTRL_MEM_TO_REG]   = 1'b1;
                fmt                         = IMM_I;
                {use_rs1, use_rd}           = 2'b11;
            end
            OP_STORE: begin
                ctrl_raw[CTRL_ALU_SRC]      = 1'b1;
                ctrl_raw[CTRL_MEM_WRITE]    = 1'b1;
                fmt                         = IMM_S;
                {use_rs1, use_rs2}          = 2'b11;
            end
            OP_BRANCH: begin
                ctrl_raw[CTRL_BRANCH]       = 1'b1;
                ctrl_raw[CTRL_ALU_OP +: 2]  = ALU_OP_BRANCH;
                fmt                         = IMM_B;
                {use_rs1, use_rs2}          = 2'b11;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl_raw[CTRL_REG_WRITE]    = 1'b1;
                ctrl_raw[CTRL_ALU_SRC]      = 1'b1;
                fmt                         = IMM_U;
                use_rd                      = 1'b1;
            end
            OP_JAL: begin
                ctrl_raw[CTRL_REG_WRITE]    = 1'b1;
                ctrl_raw[CTRL_JUMP]         = 1'b1;
                fmt                         = IMM_J;
                use_rd                      = 1'b1;
            end
            OP_JALR: begin
                ctrl_raw[CTRL_REG_WRITE]    = 1'b1;
                ctrl_raw[CTRL_ALU_SRC]      = 1'b1;
                ctrl_raw[CTRL_JUMP]         = 1'b1;
                fmt                         = IMM_I;
                {use_rs1, use_rd}           = 2'b11;
            end
            default: known = 1'b0;
        endcase
    end

    // A 16-entry file has no x16..x31, so naming one in a live field is illegal
    assign bad_reg   = SMALL_RF && ((use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) ||
                                    (use_rd && rd_f[4]));
    assign illegal_d = !known || bad_reg;
    assign ctrl_d    = illegal_d ? '0 : ctrl_raw;
    assign imm_d     = XLEN'(gen_imm(i_if_id_instruction, fmt));

    decode_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk      (i_clk),
        .rst      (i_reset),
        .rs1      (rs1_f),
        .rs2      (rs2_f),
        .rs1_data (rs1_data_d),
        .rs2_data (rs2_data_d),
        .we       (i_wb_we),
        .wr_rd    (i_wb_rd),
        .wr_data  (i_wb_data)
    );

    // ---- ID/EX boundary: p0 = decode combinational, p1 = registered ----
    logic              vld_p1, illegal_p1;
    logic [XLEN-1:0]   pc_p1, rs1_data_p1, rs2_data_p1, imm_p1;
    logic [4:0]        rs1_p1, rs2_p1, rd_p1;
    logic [CTRL_W-1:0] ctrl_p1;

    // Load-use hazard against the load now sitting in ID/EX; a flush overrides it
    assign o_stall = !i_flush && vld_p1 && ctrl_p1[CTRL_MEM_READ] && rd_p1 != 5'd0 &&
                     ((use_rs1 && rs1_f == rd_p1) || (use_rs2 && rs2_f == rd_p1));

    // ID/EX update: flush beats hold, hold beats stall bubble, otherwise load decode
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_p1      <= 1'b0;
            illegal_p1  <= 1'b0;
            ctrl_p1     <= '0;
            pc_p1       <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
        end else if (i_flush) begin
            vld_p1      <= 1'b0;
            ctrl_p1     <= '0;
            illegal_p1  <= 1'b0;
        end else if (!i_ex_hold) begin
            if (o_stall) begin
                vld_p1      <= 1'b0;
                ctrl_p1     <= '0;
                illegal_p1  <= 1'b0;
            end else begin
                vld_p1      <= i_if_id_valid;
                ctrl_p1     <= i_if_id_valid ? ctrl_d : '0;
                illegal_p1  <= i_if_id_valid && illegal_d;
                pc_p1       <= i_if_id_pc;
                rs1_data_p1 <= rs1_data_d;
                rs2_data_p1 <= rs2_data_d;
                imm_p1      <= imm_d;
                rs1_p1      <= rs1_f;
                rs2_p1      <= rs2_f;
                rd_p1       <= rd_f;
            end
        end
    end

    assign o_ex_valid    = vld_p1;
    assign o_ex_pc       = pc_p1;
    assign o_ex_rs1_data = rs1_data_p1;
    assign o_ex_rs2_data = rs2_data_p1;
    assign o_ex_imm      = imm_p1;
    assign o_ex_rs1      = rs1_p1;
    assign o_ex_rs2      = rs2_p1;
    assign o_ex_rd       = rd_p1;
    assign o_ex_ctrl     = ctrl_p1;
    assign o_ex_illegal  = illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a behavioural pipeline/register-file model.
module tb_decode_stage;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_if_id_valid = 1'b0;
    logic [31:0] i_if_id_pc = '0;
    logic [31:0] i_if_id_instruction = '0;
    logic        i_wb_we = 1'b0;
    logic [4:0]  i_wb_rd = '0;
    logic [31:0] i_wb_data = '0;
    logic        i_ex_hold = 1'b0;
    logic        i_flush = 1'b0;

    logic        stall, ex_valid, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [8:0]  ex_ctrl;

    logic        s_stall, s_ex_valid, s_ex_illegal;
    logic [31:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
    logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [8:0]  s_ex_ctrl;

    always #5 i_clk = ~i_clk;

    decode_stage #(.XLEN(32), .NREG(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_if_id_valid(i_if_id_valid),
        .i_if_id_pc(i_if_id_pc), .i_if_id_instruction(i_if_id_instruction),
        .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .i_ex_hold(i_ex_hold), .i_flush(i_flush), .o_stall(stall),
        .o_ex_valid(ex_valid), .o_ex_pc(ex_pc), .o_ex_rs1_data(ex_rs1_data),
        .o_ex_rs2_data(ex_rs2_data), .o_ex_imm(ex_imm), .o_ex_rs1(ex_rs1),
        .o_ex_rs2(ex_rs2), .o_ex_rd(ex_rd), .o_ex_ctrl(ex_ctrl),
        .o_ex_illegal(ex_illegal));

    decode_stage #(.XLEN(32), .NREG(16)) dut16 (
        .i_clk(i_clk), .i_reset(i_reset), .i_if_id_valid(i_if_id_valid),
        .i_if_id_pc(i_if_id_pc), .i_if_id_instruction(i_if_id_instruction),
        .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .i_ex_hold(i_ex_hold), .i_flush(i_flush), .o_stall(s_stall),
        .o_ex_valid(s_ex_valid), .o_ex_pc(s_ex_pc), .o_ex_rs1_data(s_ex_rs1_data),
        .o_ex_rs2_data(s_ex_rs2_data), .o_ex_imm(s_ex_imm), .o_ex_rs1(s_ex_rs1),
        .o_ex_rs2(s_ex_rs2), .o_ex_rd(s_ex_rd), .o_ex_ctrl(s_ex_ctrl),
        .o_ex_illegal(s_ex_illegal));

    wire [153:0] act_bus = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                            ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_illegal};
    wire [153:0] s_act_bus = {s_ex_valid, s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm,
                              s_ex_rs1, s_ex_rs2, s_ex_rd, s_ex_ctrl, s_ex_illegal};

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] imm;
        logic        use1;
        logic        use2;
        logic        ill;
    } dec_t;

    logic        m_valid, m_ill;
    logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [8:0]  m_ctrl;
    logic [31:0] m_regs [32];

    function automatic dec_t m_decode(input logic [31:0] ins, input int nreg);
        dec_t d;
        logic rw, as, mr, mw, mtr, br, jp, urd, known;
        logic [1:0] aop;
        int imm_i, imm_s, imm_b, imm_u, imm_j, iv;
        {rw, as, mr, mw, mtr, br, jp, urd} = '0;
        aop = 2'd0; known = 1'b1; iv = 0; d = '0;
        imm_i = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
        imm_s = int'(ins[11:7]) + 32 * int'(ins[30:25]) - (ins[31] ? 2048 : 0);
        imm_b = 2 * int'(ins[11:8]) + 32 * int'(ins[30:25]) + 2048 * int'(ins[7])
                - (ins[31] ? 4096 : 0);
        imm_u = int'(ins[31:12]) * 4096;
        imm_j = 2 * int'(ins[30:21]) + 2048 * int'(ins[20]) + 4096 * int'(ins[19:12])
                - (ins[31] ? (1 << 20) : 0);
        case (ins[6:0])
            7'h33: begin rw = 1; aop = 2; d.use1 = 1; d.use2 = 1; urd = 1; end
            7'h13: begin rw = 1; as = 1; aop = 3; d.use1 = 1; urd = 1; iv = imm_i; end
            7'h03: begin rw = 1; as = 1; mr = 1; mtr = 1; d.use1 = 1; urd = 1; iv = imm_i; end
            7'h23: begin as = 1; mw = 1; d.use1 = 1; d.use2 = 1; iv = imm_s; end
            7'h63: begin br = 1; aop = 1; d.use1 = 1; d.use2 = 1; iv = imm_b; end
            7'h37, 7'h17: begin rw = 1; as = 1; urd = 1; iv = imm_u; end
            7'h6F: begin rw = 1; jp = 1; urd = 1; iv = imm_j; end
            7'h67: begin rw = 1; as = 1; jp = 1; d.use1 = 1; urd = 1; iv = imm_i; end
            default: known = 1'b0;
        endcase
        d.imm = 32'(iv);
        d.ill = !known || (nreg == 16 && ((d.use1 && ins[19:15] >= 5'd16) ||
                (d.use2 && ins[24:20] >= 5'd16) || (urd && ins[11:7] >= 5'd16)));
        d.ctrl = d.ill ? 9'd0 : {rw, as, mr, mw, mtr, br, jp, aop};
        return d;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (BYP && i_wb_we && i_wb_rd == r) return i_wb_data;
        return m_regs[r];
    endfunction

    function automatic logic m_stall();
        dec_t d;
        d = m_decode(i_if_id_instruction, 32);
        return !i_flush && m_valid && m_ctrl[6] && m_rd != 5'd0 &&
               ((d.use1 && i_if_id_instruction[19:15] == m_rd) ||
                (d.use2 && i_if_id_instruction[24:20] == m_rd));
    endfunction

    function automatic logic [153:0] m_bus();
        return {m_valid, m_pc, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd, m_ctrl, m_ill};
    endfunction

    task automatic model_reset();
        {m_valid, m_ill, m_pc, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd, m_ctrl} = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    // advance one clock; model follows the same inputs
    task automatic tick();
        dec_t d;
        logic st;
        logic [31:0] r1, r2;
        d  = m_decode(i_if_id_instruction, 32);
        st = m_stall();
        r1 = m_read(i_if_id_instruction[19:15]);
        r2 = m_read(i_if_id_instruction[24:20]);
        @(posedge i_clk);
        #1;
        if (i_flush) begin
            m_valid = 0; m_ctrl = 0; m_ill = 0;
        end else if (!i_ex_hold) begin
            if (st) begin
                m_valid = 0; m_ctrl = 0; m_ill = 0;
            end else begin
                m_valid = i_if_id_valid;
                m_ctrl  = i_if_id_valid ? d.ctrl : 9'd0;
                m_ill   = i_if_id_valid && d.ill;
                m_pc    = i_if_id_pc;
                m_rs1d  = r1;
                m_rs2d  = r2;
                m_imm   = d.imm;
                m_rs1   = i_if_id_instruction[19:15];
                m_rs2   = i_if_id_instruction[24:20];
                m_rd    = i_if_id_instruction[11:7];
            end
        end
        if (i_wb_we && i_wb_rd != 5'd0) m_regs[i_wb_rd] = i_wb_data;
    endtask

    task automatic idle();
        i_if_id_valid = 0; i_flush = 0; i_ex_hold = 0; i_wb_we = 0;
        i_wb_rd = 0; i_wb_data = 0;
    endtask

    task automatic do_reset();
        idle();
        i_reset = 1;
        @(posedge i_clk);
        #1;
        i_reset = 0;
        model_reset();
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks++;
        if (act_bus !== 154'd0 || stall !== 1'b0) begin
            errors++; $display("FAIL reset_state: got %h stall %b, want 0", act_bus, stall);
        end
        checks++;
        if (s_act_bus !== 154'd0) begin
            errors++; $display("FAIL reset_state16: got %h, want 0", s_act_bus);
        end
        do_reset();
    endtask

    task automatic test_addi();
        do_reset();
        i_if_id_valid = 1; i_if_id_pc = 32'h100; i_if_id_instruction = 32'hFFF00293;
        tick();
        checks++;
        if (ex_imm !== 32'hFFFFFFFF || ex_rd !== 5'd5 || ex_pc !== 32'h100 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL addi_fields: imm %h rd %0d pc %h v %b, want FFFFFFFF 5 100 1",
                               ex_imm, ex_rd, ex_pc, ex_valid);
        end
        checks++;
        if (ex_ctrl[8] !== 1'b1 || ex_ctrl[7] !== 1'b1 || ex_illegal !== 1'b0) begin
            errors++; $display("FAIL addi_ctrl: ctrl %b ill %b, want reg_write=1 alu_src=1 ill=0",
                               ex_ctrl, ex_illegal);
        end
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        i_if_id_valid = 1; i_if_id_instruction = enc_i(7'h03, 5'd6, 5'd1, 3'd2, 12'd0);
        tick();
        i_if_id_instruction = enc_r(5'd7, 5'd6, 5'd1);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b want 1", stall); end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0) begin
            errors++; $display("FAIL load_use_bubble: valid %b ctrl %b, want 0 0", ex_valid, ex_ctrl);
        end
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL load_use_once: got %b want 0", stall); end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_rs1 !== 5'd6 || ex_rd !== 5'd7) begin
            errors++; $display("FAIL load_use_issue: v %b rs1 %0d rd %0d, want 1 6 7", ex_valid, ex_rs1, ex_rd);
        end
        // LW x0 never creates a hazard
        i_if_id_instruction = enc_i(7'h03, 5'd0, 5'd1, 3'd2, 12'd4);
        tick();
        i_if_id_instruction = enc_r(5'd7, 5'd0, 5'd0);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL lw_x0_stall: got %b want 0", stall); end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        i_if_id_valid = 1; i_if_id_instruction = enc_i(7'h03, 5'd6, 5'd1, 3'd2, 12'd0);
        tick();
        i_if_id_instruction = enc_r(5'd7, 5'd6, 5'd1); i_flush = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0) begin
            errors++; $display("FAIL flush_valid: v %b ctrl %b, want 0 0", ex_valid, ex_ctrl);
        end
        // flush outranks hold
        i_flush = 0; i_if_id_instruction = enc_i(7'h13, 5'd4, 5'd1, 3'd0, 12'd3);
        tick();
        i_flush = 1; i_ex_hold = 1;
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_over_hold: v %b want 0", ex_valid); end
        idle();
    endtask

    task automatic test_hold();
        do_reset();
        i_if_id_valid = 1; i_if_id_pc = 32'h200; i_if_id_instruction = enc_i(7'h13, 5'd5, 5'd1, 3'd0, 12'd7);
        tick();
        i_ex_hold = 1; i_if_id_pc = 32'h204; i_if_id_instruction = enc_r(5'd9, 5'd2, 5'd3);
        tick();
        checks++;
        if (ex_pc !== 32'h200 || ex_rd !== 5'd5 || ex_imm !== 32'd7) begin
            errors++; $display("FAIL hold_keep: pc %h rd %0d imm %h, want 200 5 7", ex_pc, ex_rd, ex_imm);
        end
        // hold beats the load-use bubble; the stall then resolves after release
        i_ex_hold = 0; i_if_id_instruction = enc_i(7'h03, 5'd6, 5'd1, 3'd2, 12'd0);
        tick();
        i_ex_hold = 1; i_if_id_instruction = enc_r(5'd7, 5'd1, 5'd6);
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || stall !== 1'b1) begin
            errors++; $display("FAIL hold_over_stall: v %b rd %0d stall %b, want 1 6 1", ex_valid, ex_rd, stall);
        end
        i_ex_hold = 0;
        tick();
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_rs2 !== 5'd6) begin
            errors++; $display("FAIL hold_then_issue: v %b rd %0d rs2 %0d, want 1 7 6", ex_valid, ex_rd, ex_rs2);
        end
        idle();
    endtask

    task automatic test_wb_bypass();
        do_reset();
        i_wb_we = 1; i_wb_rd = 5'd3; i_wb_data = 32'h11111111;
        tick();
        i_if_id_valid = 1; i_if_id_instruction = enc_i(7'h13, 5'd8, 5'd3, 3'd0, 12'd0);
        i_wb_data = 32'hDEADBEEF;
        tick();
        checks++;
        if (ex_rs1_data !== (BYP ? 32'hDEADBEEF : 32'h11111111)) begin
            errors++; $display("FAIL wb_same_cycle: got %h want %h", ex_rs1_data,
                               BYP ? 32'hDEADBEEF : 32'h11111111);
        end
        i_wb_we = 0;
        tick();
        checks++;
        if (ex_rs1_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wb_after: got %h want DEADBEEF", ex_rs1_data);
        end
        i_wb_we = 1; i_wb_rd = 5'd0; i_wb_data = 32'hFFFF0000;
        i_if_id_instruction = enc_r(5'd9, 5'd0, 5'd0);
        tick();
        i_wb_we = 0;
        tick();
        checks++;
        if (ex_rs1_data !== 32'd0 || ex_rs2_data !== 32'd0) begin
            errors++; $display("FAIL x0_zero: got %h %h want 0 0", ex_rs1_data, ex_rs2_data);
        end
        idle();
    endtask

    task automatic test_illegal();
        do_reset();
        i_if_id_valid = 1; i_if_id_instruction = 32'h0000007F;
        tick();
        checks++;
        if (ex_illegal !== 1'b1 || ex_ctrl !== 9'd0 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL bad_opcode: ill %b ctrl %b v %b, want 1 0 1", ex_illegal, ex_ctrl, ex_valid);
        end
        i_if_id_instruction = enc_i(7'h13, 5'd20, 5'd1, 3'd0, 12'd5);
        tick();
        checks++;
        if (s_ex_illegal !== 1'b1 || s_ex_ctrl !== 9'd0 || ex_illegal !== 1'b0) begin
            errors++; $display("FAIL nreg16_rd20: ill16 %b ctrl16 %b ill32 %b, want 1 0 0",
                               s_ex_illegal, s_ex_ctrl, ex_illegal);
        end
        i_if_id_instruction = enc_r(5'd3, 5'd1, 5'd17);
        tick();
        checks++;
        if (s_ex_illegal !== 1'b1 || s_ex_ctrl !== 9'd0) begin
            errors++; $display("FAIL nreg16_rs2_17: ill %b ctrl %b, want 1 0", s_ex_illegal, s_ex_ctrl);
        end
        i_if_id_instruction = enc_r(5'd3, 5'd1, 5'd2);
        tick();
        checks++;
        if (s_ex_illegal !== 1'b0 || s_ex_ctrl !== 9'h102) begin
            errors++; $display("FAIL nreg16_legal: ill %b ctrl %h, want 0 102", s_ex_illegal, s_ex_ctrl);
        end
        i_if_id_valid = 0; i_if_id_instruction = 32'h0000007F;
        tick();
        checks++;
        if (ex_illegal !== 1'b0 || ex_valid !== 1'b0) begin
            errors++; $display("FAIL invalid_slot: ill %b v %b, want 0 0", ex_illegal, ex_valid);
        end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        i_if_id_valid = 1; i_if_id_instruction = enc_i(7'h03, 5'd6, 5'd1, 3'd2, 12'd0);
        i_wb_we = 1; i_wb_rd = 5'd3; i_wb_data = 32'h12345678;
        tick();
        i_wb_we = 0; i_if_id_instruction = enc_r(5'd7, 5'd6, 5'd3);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b want 1", stall); end
        #1 i_reset = 1;
        #1;
        checks++;
        if (act_bus !== 154'd0 || stall !== 1'b0 || s_act_bus !== 154'd0) begin
            errors++; $display("FAIL async_reset: bus %h stall %b bus16 %h, want 0", act_bus, stall, s_act_bus);
        end
        model_reset();
        i_reset = 0;
        #1;
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_rs2_data !== 32'd0 || act_bus !== m_bus()) begin
            errors++; $display("FAIL post_reset_edge: got %h want %h", act_bus, m_bus());
        end
        idle();
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        logic [31:0] ins;
        logic exp_st;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 9)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            i_if_id_instruction = ins;
            i_if_id_valid = ($urandom_range(0, 7) != 0);
            i_if_id_pc    = $urandom;
            i_flush       = ($urandom_range(0, 9) == 0);
            i_ex_hold     = ($urandom_range(0, 5) == 0);
            i_wb_we       = $urandom_range(0, 1) == 1;
            i_wb_rd       = 5'($urandom_range(0, 7));
            i_wb_data     = $urandom;
            #1;
            exp_st = m_stall();
            checks++;
            if (stall !== exp_st) begin
                errors++; $display("FAIL rand_stall[%0d]: got %b want %b", n, stall, exp_st);
            end
            tick();
            checks++;
            if (act_bus !== m_bus()) begin
                errors++; $display("FAIL rand_idex[%0d]: got %h want %h", n, act_bus, m_bus());
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_addi();
        test_load_use();
        test_flush();
        test_hold();
        test_wb_bypass();
        test_illegal();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
